decoder_scan_ctrl: RTL and testbench

Scan sequencer that drives the select inputs (A, B, C) and active-high enable (en) of the 3-to-8 active-low decoder. It steps through the eight decoder outputs in ascending index order, skipping masked lines. Each selected line gets a programmable dwell time, separated by a blanking gap with en low, so the downstream active-low strobes (multiplexed display digits or row drivers) never overlap or ghost. All outputs are registered and connect directly to the decoder ports.

---
 rtl/decoder_scan_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//
// Scan sequencer for a 3-to-8 active-low decoder. It steps through the
// decoder outputs in ascending index order and skips masked lines. Each
// selected line is preceded by a blanking gap (en low) and then held for a
// dwell period (en high), so the downstream strobes never overlap.
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high reset
//   run         in   1 = scanning requested, 0 = stop (level, not a handshake)
//   digit_mask  in   [7:0] bit i enables decoder output i; sampled at frame
//                    boundaries and when scanning starts from IDLE
//   A, B, C     out  registered line select, {A,B,C} = current index
//   en          out  registered decoder enable, high only while dwelling
//   frame_done  out  registered one-cycle pulse when a full frame completes
//   dbg_state   out  [1:0] current FSM state (0 IDLE, 1 BLANK, 2 DWELL)
//
// Handshake note: this block has no valid/ready interface. run is sampled as
// a level on every rising edge; digit_mask is captured into a shadow register
// only when a frame starts, so mid-frame mask changes have no effect.
//
// Parameters:
//   PRESCALE     clock cycles per scan tick (>= 1)
//   DWELL_TICKS  ticks with en high per line (>= 1)
//   BLANK_TICKS  ticks with en low before each line (0 = no blanking)

module decoder_scan_ctrl #(
  parameter int PRESCALE    = 1000,
  parameter int DWELL_TICKS = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] digit_mask,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       en,
  output logic       frame_done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int MAXT = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam bit            NO_BLANK   = (BLANK_TICKS == 0);

  state_t          state, state_n;
  logic [PW-1:0]   pre_cnt, pre_n;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic [7:0]      shadow, shadow_n;
  logic [2:0]      idx, idx_n;
  logic            fd_n;
  logic            tick;
  logic            has_higher;
  logic [2:0]      next_idx;

  // Lowest set bit index of a non-zero mask.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // A new line always begins with blanking unless blanking is disabled,
  // in which case it goes straight to dwell.
  function automatic state_t line_start();
    if (NO_BLANK) return DWELL;
    return BLANK;
  endfunction

  assign tick = (pre_cnt == PRE_LAST);

  // Next enabled line strictly above the current index; no wrap here, the
  // wrap back to the lowest line happens only through the frame boundary.
  always_comb begin
    has_higher = 1'b0;
    next_idx   = idx;
    for (int i = 7; i >= 0; i--) begin
      if (shadow[i] && (3'(i) > idx)) begin
        has_higher = 1'b1;
        next_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    shadow_n = shadow;
    tcnt_n   = tcnt;
    fd_n     = 1'b0;
    pre_n    = tick ? '0 : pre_cnt + PW'(1);

    case (state)
      IDLE: begin
        // Holding the prescaler at zero makes every exit from IDLE start
        // with a fresh, full-length first tick.
        pre_n  = '0;
        tcnt_n = '0;
        if (run && (digit_mask != 8'h00)) begin
          shadow_n = digit_mask;
          idx_n    = lowest_set(digit_mask);
          state_n  = line_start();
        end
      end

      BLANK: begin
        if (!run) begin
          state_n = IDLE;
          pre_n   = '0;
          tcnt_n  = '0;
        end else if (tick) begin
          if (tcnt == BLANK_LAST) begin
            state_n = DWELL;
            tcnt_n  = '0;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end

      DWELL: begin
        // Stop wins over a coincident end of frame: no frame_done pulse.
        if (!run) begin
          state_n = IDLE;
          pre_n   = '0;
          tcnt_n  = '0;
        end else if (tick) begin
          if (tcnt == DWELL_LAST) begin
            tcnt_n = '0;
            if (has_higher) begin
              idx_n   = next_idx;
              state_n = line_start();
            end else begin
              fd_n     = 1'b1;
              shadow_n = digit_mask;
              if (digit_mask != 8'h00) begin
                idx_n   = lowest_set(digit_mask);
                state_n = line_start();
              end else begin
                state_n = IDLE;
              end
            end
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end

      default: begin
        state_n = IDLE;
        pre_n   = '0;
        tcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      tcnt       <= '0;
      shadow     <= 8'h00;
      idx        <= 3'b000;
      en         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      pre_cnt    <= pre_n;
      tcnt       <= tcnt_n;
      shadow     <= shadow_n;
      idx        <= idx_n;
      // en is registered from the next state, so index changes and en
      // falling land on the same edge.
      en         <= (state_n == DWELL);
      frame_done <= fd_n;
    end
  end

  assign {A, B, C} = idx;
  assign dbg_state = state;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl
//
// Two instances share the clock and reset:
//   dut0: PRESCALE=2, DWELL_TICKS=2, BLANK_TICKS=1
//   dut1: PRESCALE=3, DWELL_TICKS=2, BLANK_TICKS=0
// A behavioural model tracks, per instance, whether a frame is active, the
// current line, whether the line is blanking or dwelling, and how many clock
// cycles remain in that segment. At every rising edge it pushes the expected
// outputs into exp_q; a negedge process pops and compares every cycle.
// Directed literal checks pin the model to hand-computed timelines.

module tb_decoder_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       run0, run1;
  logic [7:0] mask0, mask1;
  logic       a0, b0, c0, en0, fd0;
  logic       a1, b1, c1, en1, fd1;
  logic [1:0] st0, st1;

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  logic [9:0] exp_q[$];

  // model state, index 0 -> dut0, index 1 -> dut1
  bit         m_act[2];
  bit         m_blk[2];
  int         m_line[2];
  int         m_rem[2];
  logic [7:0] m_shadow[2];
  bit         m_fd[2];

  decoder_scan_ctrl #(.PRESCALE(2), .DWELL_TICKS(2), .BLANK_TICKS(1)) dut0 (
    .clk(clk), .reset(rst), .run(run0), .digit_mask(mask0),
    .A(a0), .B(b0), .C(c0), .en(en0), .frame_done(fd0), .dbg_state(st0)
  );

  decoder_scan_ctrl #(.PRESCALE(3), .DWELL_TICKS(2), .BLANK_TICKS(0)) dut1 (
    .clk(clk), .reset(rst), .run(run1), .digit_mask(mask1),
    .A(a1), .B(b1), .C(c1), .en(en1), .frame_done(fd1), .dbg_state(st1)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic lit(input int k, input string nm, input int e_en, input int e_idx, input int e_fd);
    if (k == 0) begin
      chk({nm, "_en"},  int'(en0), e_en);
      chk({nm, "_idx"}, int'({a0, b0, c0}), e_idx);
      chk({nm, "_fd"},  int'(fd0), e_fd);
    end else begin
      chk({nm, "_en"},  int'(en1), e_en);
      chk({nm, "_idx"}, int'({a1, b1, c1}), e_idx);
      chk({nm, "_fd"},  int'(fd1), e_fd);
    end
  endtask

  // advance to the negedge sampling cycle c (cycle 0 follows the start edge)
  task automatic adv(input int c);
    while (cur < c) begin
      @(negedge clk);
      cur++;
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int higher(input logic [7:0] m, input int line);
    for (int i = line + 1; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic start_line(input int k, input int line, input int bc, input int dc);
    m_line[k] = line;
    if (bc > 0) begin
      m_blk[k] = 1'b1;
      m_rem[k] = bc;
    end else begin
      m_blk[k] = 1'b0;
      m_rem[k] = dc;
    end
  endtask

  // bc/dc: blanking and dwell lengths in clock cycles
  task automatic step(input int k, input bit r, input logic [7:0] m, input int bc, input int dc);
    int h;
    m_fd[k] = 1'b0;
    if (!m_act[k]) begin
      if (r && (m != 8'h00)) begin
        m_act[k]    = 1'b1;
        m_shadow[k] = m;
        start_line(k, lowest(m), bc, dc);
      end
    end else if (!r) begin
      m_act[k] = 1'b0;
    end else if (m_rem[k] > 1) begin
      m_rem[k]--;
    end else if (m_blk[k]) begin
      m_blk[k] = 1'b0;
      m_rem[k] = dc;
    end else begin
      h = higher(m_shadow[k], m_line[k]);
      if (h >= 0) begin
        start_line(k, h, bc, dc);
      end else begin
        m_fd[k]     = 1'b1;
        m_shadow[k] = m;
        if (m != 8'h00) start_line(k, lowest(m), bc, dc);
        else m_act[k] = 1'b0;
      end
    end
  endtask

  function automatic logic [4:0] pack(input int k);
    return {m_fd[k], (m_act[k] && !m_blk[k]), 3'(m_line[k])};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_blk[k] = 0; m_line[k] = 0;
        m_rem[k] = 0; m_shadow[k] = 8'h00; m_fd[k] = 0;
      end
    end else begin
      step(0, run0, mask0, 2 * 1, 2 * 2);
      step(1, run1, mask1, 0, 3 * 2);
    end
    exp_q.push_back({pack(1), pack(0)});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : cmp
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL exp_q_empty got=0 exp=1 t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("m_en0",  int'(en0),          int'(e[3]));
      chk("m_idx0", int'({a0, b0, c0}), int'(e[2:0]));
      chk("m_fd0",  int'(fd0),          int'(e[4]));
      chk("m_en1",  int'(en1),          int'(e[8]));
      chk("m_idx1", int'({a1, b1, c1}), int'(e[7:5]));
      chk("m_fd1",  int'(fd1),          int'(e[9]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    run0  = 1'b1;
    run1  = 1'b1;
    mask0 = 8'hFF;
    mask1 = 8'hFF;

    // reset held 3 cycles with run and a full mask
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit(0, "rst0", 0, 0, 0);
      lit(1, "rst1", 0, 0, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    // first edge after release already starts scanning
    lit(0, "rel0", 0, 0, 0);
    lit(1, "rel1", 1, 0, 0);

    run0 = 1'b0;
    run1 = 1'b0;
    repeat (2) @(negedge clk);

    // basic frame on dut0, mask 1000_0101
    mask0 = 8'b1000_0101;
    run0  = 1'b1;
    cur   = -1;
    adv(0);  lit(0, "bf_c0", 0, 0, 0);
    adv(1);  lit(0, "bf_c1", 0, 0, 0);
    adv(2);  lit(0, "bf_c2", 1, 0, 0);
    adv(5);  lit(0, "bf_c5", 1, 0, 0);
    adv(6);  lit(0, "bf_c6", 0, 2, 0);
    adv(8);  lit(0, "bf_c8", 1, 2, 0);
    adv(11); lit(0, "bf_c11", 1, 2, 0);
    adv(12); lit(0, "bf_c12", 0, 7, 0);
    adv(14); lit(0, "bf_c14", 1, 7, 0);
    adv(17); lit(0, "bf_c17", 1, 7, 0);
    adv(18); lit(0, "bf_c18", 0, 0, 1);
    adv(19); lit(0, "bf_c19", 0, 0, 0);

    // mid-frame mask change during idx 2 of the second frame
    adv(27); lit(0, "mid_c27", 1, 2, 0);
    mask0 = 8'h10;
    adv(30); lit(0, "mid_c30", 0, 7, 0);
    adv(32); lit(0, "mid_c32", 1, 7, 0);
    adv(36); lit(0, "mid_c36", 0, 4, 1);
    adv(38); lit(0, "mid_c38", 1, 4, 0);
    adv(41); lit(0, "mid_c41", 1, 4, 0);
    adv(42); lit(0, "mid_c42", 0, 4, 1);
    adv(45); lit(0, "mid_c45", 1, 4, 0);
    adv(48); lit(0, "mid_c48", 0, 4, 1);

    // stop during dwell on idx 2
    adv(49);
    run0  = 1'b0;
    mask0 = 8'h85;
    adv(51);
    run0 = 1'b1;
    cur  = -1;
    adv(9); lit(0, "stop_c9", 1, 2, 0);
    run0 = 1'b0;
    for (int c = 10; c <= 14; c++) begin
      adv(c);
      lit(0, "stop_hold", 0, 2, 0);
    end
    run0 = 1'b1;
    cur  = -1;
    adv(0); lit(0, "rs_c0", 0, 0, 0);
    adv(1); lit(0, "rs_c1", 0, 0, 0);
    adv(2); lit(0, "rs_c2", 1, 0, 0);
    run0 = 1'b0;
    adv(4);

    // empty mask with run high stays idle
    mask0 = 8'h00;
    run0  = 1'b1;
    for (int c = 5; c <= 9; c++) begin
      adv(c);
      lit(0, "empty", 0, 0, 0);
    end
    // one-line frame whose mask empties before the boundary
    mask0 = 8'h04;
    cur   = -1;
    adv(0); lit(0, "mz_c0", 0, 2, 0);
    adv(1);
    mask0 = 8'h00;
    adv(2); lit(0, "mz_c2", 1, 2, 0);
    adv(5); lit(0, "mz_c5", 1, 2, 0);
    adv(6); lit(0, "mz_c6", 0, 2, 1);
    adv(7); lit(0, "mz_c7", 0, 2, 0);
    adv(9); lit(0, "mz_c9", 0, 2, 0);

    // zero blanking on dut1, mask 03, dwell 6 cycles
    mask1 = 8'h03;
    run1  = 1'b1;
    cur   = -1;
    for (int c = 0; c < 24; c++) begin
      adv(c);
      chk("zb_en", int'(en1), 1);
    end
    cur = -1;
    run1 = 1'b0;
    adv(2);
    run1 = 1'b1;
    cur  = -1;
    adv(0);  lit(1, "zb_c0", 1, 0, 0);
    adv(5);  lit(1, "zb_c5", 1, 0, 0);
    adv(6);  lit(1, "zb_c6", 1, 1, 0);
    adv(11); lit(1, "zb_c11", 1, 1, 0);
    adv(12); lit(1, "zb_c12", 1, 0, 1);
    adv(13); lit(1, "zb_c13", 1, 0, 0);
    adv(18); lit(1, "zb_c18", 1, 1, 0);

    // randomized phase, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      if (run0) run0 = ($urandom_range(0, 99) >= 3);
      else      run0 = ($urandom_range(0, 99) < 25);
      if (run1) run1 = ($urandom_range(0, 99) >= 3);
      else      run1 = ($urandom_range(0, 99) < 25);
      if ($urandom_range(0, 99) < 5)
        mask0 = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 5)
        mask1 = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
